reg_fifo_unpack: RTL and testbench
==================================

# reg_fifo_unpack

Parametrised FIFO-to-register-bus unpacker in the `cwusb_clk` domain. It sits between the main register block and the capture FIFO. It pops one FIFO word per register-bus word read and serialises `{status, data}` onto the 8-bit read bus as a fixed-length frame: one header byte followed by payload bytes. It serves both addressed register reads and fast (address-less) streaming reads, substitutes an empty marker when the FIFO is empty, and can optionally keep read statistics.

## Interface
Parameters:
- pDATA_WIDTH, 18, FIFO data width.
- pSTATUS_WIDTH, 6, FIFO status width appended above data.
- pBYTECNT_SIZE, 7, register-bus byte counter width.
- pEMPTY_DATA, 0, data field value placed in an empty-marker frame.
- Derived localparam pWORD_BYTES = 1 + ceil((pDATA_WIDTH+pSTATUS_WIDTH)/8). With the defaults this is 4.

Ports (single clock; reset is synchronous and active-high):
- cwusb_clk  in  1  sole clock.
- fpga_reset  in  1  synchronous active-high reset.
- I_sel  in  1  register decode: FIFO register addressed and address valid.
- reg_read  in  1  register read flag.
- reg_bytecnt  in  pBYTECNT_SIZE  register-bus byte count.
- I_fast_en  in  1  fast-read mode enable.
- I_fast_rd  in  1  fast-read byte strobe, one per byte.
- I_fast_restart  in  1  resets the fast byte index to 0.
- I_fifo_data  in  pDATA_WIDTH  first-word-fall-through (FWFT) FIFO head.
- I_fifo_status  in  pSTATUS_WIDTH  FIFO status, sampled with the word.
- I_fifo_empty  in  1  FIFO empty.
- O_fifo_read  out  1  FIFO pop, one cycle per frame.
- O_read_data  out  8  registered read byte.
- O_fast_active  out  1  high while a fast frame is partially served.
- I_clear_counts  in  1  clears the statistics counters.
- O_word_count  out  32  words popped.
- O_empty_count  out  16  empty-marker frames served.

## Operation
- Byte index:
  - Register path: idx = reg_bytecnt mod pWORD_BYTES.
  - Fast path: idx comes from an internal counter fidx (0..pWORD_BYTES-1). fidx advances on every accepted fast strobe and wraps to 0 after the last byte.
- Frame start:
  - Register path: frame start = I_sel & reg_read & ~reg_read_r & idx==0.
  - Fast path: frame start = I_fast_en & I_fast_rd & fidx==0.
- At frame start with I_fifo_empty=0:
  - O_fifo_read=1 in the same cycle (combinational).
  - The word register loads {I_fifo_status, I_fifo_data}.
  - empty_flag is cleared.
- At frame start with I_fifo_empty=1:
  - No pop.
  - The word register loads {I_fifo_status, pEMPTY_DATA}.
  - empty_flag is set.
- Frame layout:
  - Byte 0 is the header: {empty_flag, fast_src, 6'b0}.
  - Bytes 1..pWORD_BYTES-1 carry the word register, little-endian, zero-padded in the top bits.
- Bytes at idx≠0 are always served from the latched word. FIFO changes mid-frame have no effect on them.
- Reads at idx≠0 with no prior frame serve the reset-value word (all zero).
- Priority: a register read that is active in a cycle wins over a fast strobe in that cycle. The fast strobe is dropped, and fidx does not advance.
- I_fast_restart or a rising edge of I_fast_en sets fidx=0 and deasserts O_fast_active. A pending partial frame is abandoned.
- O_read_data outside an active read is 0.
- Statistics:
  - O_word_count increments on every O_fifo_read and wraps modulo 2^32.
  - O_empty_count increments on every empty-marker frame start and saturates at 0xFFFF.
  - I_clear_counts zeroes both counters and takes precedence over a simultaneous increment.

## Timing
- Reset: O_fifo_read=0, O_read_data=0, O_fast_active=0, O_word_count=0, O_empty_count=0. The word register, empty_flag, fidx and reg_read_r are all 0.
- O_fifo_read is asserted in cycle N, the frame-start cycle. The byte requested in cycle N appears on O_read_data at N+1, giving one-cycle read latency on both paths.
- The header byte at N+1 already reflects the empty decision made in cycle N.
- Back-to-back fast frames: the strobe at fidx==pWORD_BYTES-1 is followed by a strobe at fidx==0 in the next cycle. This produces a pop in that cycle and is legal at full rate.
- Reset asserted mid-frame clears all state within one cycle. The next read at idx 0 starts a fresh frame, and no pop is issued during reset.

## Configuration
- FIFO_RD_STATS_EN:
  - Defined: the statistics counters and I_clear_counts are implemented as described.
  - Undefined: the counters are not instantiated, O_word_count and O_empty_count are tied to 0, and I_clear_counts is ignored.

## Test plan
- FIFO holds 0x2A5C3 with status 0x15; register read of bytes 0..3 → one O_fifo_read pulse in cycle N; O_read_data = 0x00, 0xC3, 0xA5, {status,data[17:16]} at N+1..N+4; O_word_count = 1.
- FIFO empty; register read of bytes 0..3 → no pop; header = 0x80; payload bytes = pEMPTY_DATA; O_empty_count = 1.
- Fast mode with 3 words queued and 12 consecutive strobes → exactly 3 pops, spaced 4 cycles apart; header = 0x40 each frame; fidx = 0 at the end.
- Fast strobe and register read in the same cycle → register frame served; fifo pops = 1; fidx unchanged.
- 5 strobes, then I_fast_restart, then 4 strobes → 2 pops total; the second frame's header is served at byte 0.
- O_empty_count preloaded by 65536 empty frames → holds 0xFFFF; I_clear_counts together with an increment → both counters read 0.

Source files
------------

// File: rtl/reg_fifo_unpack.sv
// reg_fifo_unpack: pops one FIFO word per frame and serialises it onto the
// 8-bit register read bus as a header byte plus little-endian payload bytes.
// The word is reached through addressed register reads or address-less fast reads.
// Optional feature macro: FIFO_RD_STATS_EN (word / empty-frame statistics).
module reg_fifo_unpack #(
    parameter int pDATA_WIDTH   = 18,
    parameter int pSTATUS_WIDTH = 6,
    parameter int pBYTECNT_SIZE = 7,
    parameter logic [pDATA_WIDTH-1:0] pEMPTY_DATA = '0
) (
    input  logic                     cwusb_clk,
    input  logic                     fpga_reset,
    input  logic                     I_sel,
    input  logic                     reg_read,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic                     I_fast_en,
    input  logic                     I_fast_rd,
    input  logic                     I_fast_restart,
    input  logic [pDATA_WIDTH-1:0]   I_fifo_data,
    input  logic [pSTATUS_WIDTH-1:0] I_fifo_status,
    input  logic                     I_fifo_empty,
    output logic                     O_fifo_read,
    output logic [7:0]               O_read_data,
    output logic                     O_fast_active,
    input  logic                     I_clear_counts,
    output logic [31:0]              O_word_count,
    output logic [15:0]              O_empty_count
);

    localparam int pWORD_BITS  = pDATA_WIDTH + pSTATUS_WIDTH;
    localparam int pWORD_BYTES = 1 + (pWORD_BITS + 7) / 8;
    localparam int pPAY_BITS   = 8 * (pWORD_BYTES - 1);
    localparam int pIDX_W      = (pWORD_BYTES > 2) ? $clog2(pWORD_BYTES) : 1;
    localparam logic [pBYTECNT_SIZE-1:0] pWB_CNT = pBYTECNT_SIZE'(pWORD_BYTES);
    localparam logic [pIDX_W-1:0] pLAST_IDX = pIDX_W'(pWORD_BYTES - 1);

    logic [pWORD_BITS-1:0] word_r;
    logic                  empty_flag;
    logic                  fast_src;
    logic                  reg_read_r;
    logic                  fast_en_r;
    logic [pIDX_W-1:0]     fidx;

    logic                  reg_active;
    logic                  fast_reset;
    logic                  fast_acc;
    logic [pIDX_W-1:0]     reg_idx;
    logic [pIDX_W-1:0]     fidx_eff;
    logic [pIDX_W-1:0]     fidx_next;
    logic [pIDX_W-1:0]     sel_idx;
    logic                  reg_start;
    logic                  fast_start;
    logic                  frame_start;
    logic                  empty_start;
    logic [pWORD_BITS-1:0] word_load;
    logic [pPAY_BITS-1:0]  payload;
    logic [7:0]            header;
    logic [7:0]            frame_bytes [pWORD_BYTES];
    logic [7:0]            byte_next;

    assign reg_idx = pIDX_W'(reg_bytecnt % pWB_CNT);

    // Frame-start detection, byte index selection and the byte to register.
    // A restart (or fast_en rising) takes effect in its own cycle, so a strobe
    // arriving together with it is byte 0 of a fresh frame.
    always_comb begin
        reg_active  = I_sel & reg_read;
        fast_reset  = I_fast_restart | (I_fast_en & ~fast_en_r);
        fidx_eff    = fast_reset ? '0 : fidx;
        fast_acc    = I_fast_en & I_fast_rd & ~reg_active;
        reg_start   = reg_active & ~reg_read_r & (reg_idx == '0);
        fast_start  = fast_acc & (fidx_eff == '0);
        frame_start = (reg_start | fast_start) & ~fpga_reset;
        O_fifo_read = frame_start & ~I_fifo_empty;
        empty_start = frame_start & I_fifo_empty;
        word_load   = {I_fifo_status, (I_fifo_empty ? pEMPTY_DATA : I_fifo_data)};

        if (fast_acc)
            fidx_next = (fidx_eff == pLAST_IDX) ? '0 : fidx_eff + pIDX_W'(1);
        else
            fidx_next = fidx_eff;

        // Header must already reflect a decision being made this cycle.
        if (frame_start)
            header = {I_fifo_empty, fast_start, 6'b0};
        else
            header = {empty_flag, fast_src, 6'b0};

        payload        = pPAY_BITS'(word_r);
        frame_bytes[0] = header;
        for (int i = 1; i < pWORD_BYTES; i++)
            frame_bytes[i] = payload[8*(i-1) +: 8];

        sel_idx   = reg_active ? reg_idx : fidx_eff;
        byte_next = 8'h00;
        if (reg_active | fast_acc)
            byte_next = frame_bytes[sel_idx];
    end

    assign O_fast_active = (fidx != '0);

    // Word latch, frame flags, fast byte index and registered read byte.
    always_ff @(posedge cwusb_clk) begin
        if (fpga_reset) begin
            word_r      <= '0;
            empty_flag  <= 1'b0;
            fast_src    <= 1'b0;
            reg_read_r  <= 1'b0;
            fast_en_r   <= 1'b0;
            fidx        <= '0;
            O_read_data <= 8'h00;
        end else begin
            reg_read_r  <= reg_read;
            fast_en_r   <= I_fast_en;
            fidx        <= fidx_next;
            O_read_data <= byte_next;
            if (frame_start) begin
                word_r     <= word_load;
                empty_flag <= I_fifo_empty;
                fast_src   <= fast_start;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_count;
    logic [15:0] empty_count;

    // Pop counter wraps; empty-frame counter saturates; clear wins.
    always_ff @(posedge cwusb_clk) begin
        if (fpga_reset || I_clear_counts) begin
            word_count  <= '0;
            empty_count <= '0;
        end else begin
            if (O_fifo_read)
                word_count <= word_count + 32'd1;
            if (empty_start && (empty_count != 16'hFFFF))
                empty_count <= empty_count + 16'd1;
        end
    end

    assign O_word_count  = word_count;
    assign O_empty_count = empty_count;
`else
    logic unused_stats;
    assign unused_stats  = &{1'b0, I_clear_counts, empty_start};
    assign O_word_count  = 32'd0;
    assign O_empty_count = 16'd0;
`endif

endmodule

// File: tb/tb_reg_fifo_unpack.sv
// Testbench for reg_fifo_unpack: directed frames plus random traffic, checked
// against a transaction-level model of the frame rules and a queue-based FIFO.
module tb_reg_fifo_unpack;

    localparam int WB = 4;

    logic        cwusb_clk = 1'b0;
    logic        fpga_reset;
    logic        I_sel;
    logic        reg_read;
    logic [6:0]  reg_bytecnt;
    logic        I_fast_en;
    logic        I_fast_rd;
    logic        I_fast_restart;
    logic [17:0] I_fifo_data;
    logic [5:0]  I_fifo_status;
    logic        I_fifo_empty;
    logic        O_fifo_read;
    logic [7:0]  O_read_data;
    logic        O_fast_active;
    logic        I_clear_counts;
    logic [31:0] O_word_count;
    logic [15:0] O_empty_count;

    reg_fifo_unpack dut (
        .cwusb_clk      (cwusb_clk),
        .fpga_reset     (fpga_reset),
        .I_sel          (I_sel),
        .reg_read       (reg_read),
        .reg_bytecnt    (reg_bytecnt),
        .I_fast_en      (I_fast_en),
        .I_fast_rd      (I_fast_rd),
        .I_fast_restart (I_fast_restart),
        .I_fifo_data    (I_fifo_data),
        .I_fifo_status  (I_fifo_status),
        .I_fifo_empty   (I_fifo_empty),
        .O_fifo_read    (O_fifo_read),
        .O_read_data    (O_read_data),
        .O_fast_active  (O_fast_active),
        .I_clear_counts (I_clear_counts),
        .O_word_count   (O_word_count),
        .O_empty_count  (O_empty_count)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [23:0] fifo_q [$];
    logic [23:0] m_word;
    bit          m_empty, m_fast, m_prev_read, m_prev_fen;
    int          m_fidx;
    logic [31:0] m_wcnt;
    int          m_ecnt;
    bit          rand_empty_status = 1'b0;
    int          pops_seen = 0;
    logic [7:0]  last_byte;
    logic [7:0]  got [16];

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic model_reset();
        m_word = '0; m_empty = 0; m_fast = 0; m_prev_read = 0; m_prev_fen = 0;
        m_fidx = 0; m_wcnt = '0; m_ecnt = 0;
    endtask

    // One clock of stimulus; model predicts pop (this cycle) and byte (next).
    task automatic do_cycle(input bit sel, input bit rd, input int bcnt,
                            input bit fen, input bit frd, input bit frst,
                            input bit clr = 1'b0);
        logic [5:0]  st;
        logic [17:0] dt;
        bit emp, reg_act, facc, start, start_fast, exp_pop;
        int fi, idx;
        logic [7:0] exp_byte;
        emp = (fifo_q.size() == 0);
        if (!emp) {st, dt} = fifo_q[0];
        else begin
            st = rand_empty_status ? 6'($urandom) : 6'h0;
            dt = 18'($urandom);
        end
        I_sel = sel; reg_read = rd; reg_bytecnt = 7'(bcnt);
        I_fast_en = fen; I_fast_rd = frd; I_fast_restart = frst;
        I_fifo_data = dt; I_fifo_status = st; I_fifo_empty = emp;
        I_clear_counts = clr;

        reg_act    = sel && rd;
        fi         = (frst || (fen && !m_prev_fen)) ? 0 : m_fidx;
        facc       = fen && frd && !reg_act;
        idx        = reg_act ? (bcnt % WB) : fi;
        start_fast = facc && (fi == 0);
        start      = (reg_act && !m_prev_read && (bcnt % WB == 0)) || start_fast;
        exp_pop    = start && !emp;
        if (start) begin
            m_word  = emp ? {st, 18'h0} : fifo_q[0];
            m_empty = emp;
            m_fast  = start_fast;
        end
        if (clr) begin
            m_wcnt = 0; m_ecnt = 0;
        end else begin
            if (exp_pop) m_wcnt = m_wcnt + 1;
            if (start && emp && m_ecnt < 65535) m_ecnt++;
        end
        if (!(reg_act || facc)) exp_byte = 8'h00;
        else if (idx == 0)      exp_byte = {m_empty, m_fast, 6'b0};
        else                    exp_byte = 8'(m_word >> (8 * (idx - 1)));
        m_fidx      = facc ? (fi + 1) % WB : fi;
        m_prev_read = rd;
        m_prev_fen  = fen;

        @(negedge cwusb_clk);
        check("pop", O_fifo_read, exp_pop);
        if (O_fifo_read) pops_seen++;
        @(posedge cwusb_clk);
        if (exp_pop) void'(fifo_q.pop_front());
        #1;
        last_byte = O_read_data;
        check("rdata", O_read_data, exp_byte);
        check("fast_active", O_fast_active, m_fidx != 0);
`ifdef FIFO_RD_STATS_EN
        check("word_count", O_word_count, m_wcnt);
        check("empty_count", O_empty_count, m_ecnt);
`else
        check("word_count", O_word_count, 0);
        check("empty_count", O_empty_count, 0);
`endif
    endtask

    task automatic do_reset();
        fpga_reset = 1'b1;
        I_sel = 1; reg_read = 1; reg_bytecnt = 0; I_fast_en = 1; I_fast_rd = 1;
        I_fast_restart = 0; I_fifo_data = 18'h1234; I_fifo_status = 6'h3;
        I_fifo_empty = 0; I_clear_counts = 0;
        repeat (2) begin
            @(negedge cwusb_clk);
            check("rst_pop", O_fifo_read, 0);
            @(posedge cwusb_clk);
            #1;
        end
        check("rst_rdata", O_read_data, 0);
        check("rst_fast_active", O_fast_active, 0);
        check("rst_word_count", O_word_count, 0);
        check("rst_empty_count", O_empty_count, 0);
        I_sel = 0; reg_read = 0; I_fast_en = 0; I_fast_rd = 0;
        fpga_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int p0;
        @(posedge cwusb_clk);
        #1;
        do_reset();

        // Register read of a known word.
        fifo_q.push_back({6'h15, 18'h2A5C3});
        p0 = pops_seen;
        for (int b = 0; b < 4; b++) begin
            do_cycle(1, 1, b, 0, 0, 0);
            got[b] = last_byte;
        end
        do_cycle(0, 0, 0, 0, 0, 0);
        check("reg_b0", got[0], 8'h00);
        check("reg_b1", got[1], 8'hC3);
        check("reg_b2", got[2], 8'hA5);
        check("reg_b3", got[3], 8'h56);
        check("reg_pops", pops_seen - p0, 1);

        // Register read with FIFO empty.
        p0 = pops_seen;
        for (int b = 0; b < 4; b++) begin
            do_cycle(1, 1, b, 0, 0, 0);
            got[b] = last_byte;
        end
        do_cycle(0, 0, 0, 0, 0, 0);
        check("empty_hdr", got[0], 8'h80);
        check("empty_b1", got[1], 8'h00);
        check("empty_b3", got[3], 8'h00);
        check("empty_pops", pops_seen - p0, 0);

        // Fast mode, three frames at full rate.
        for (int i = 0; i < 3; i++) fifo_q.push_back(24'($urandom));
        p0 = pops_seen;
        for (int i = 0; i < 12; i++) begin
            do_cycle(0, 0, 0, 1, 1, 0);
            got[i] = last_byte;
        end
        check("fast_pops", pops_seen - p0, 3);
        for (int f = 0; f < 3; f++) check("fast_hdr", got[4*f], 8'h40);
        check("fast_end_idle", O_fast_active, 0);

        // Fast strobe collides with a register read: register frame wins.
        fifo_q.push_back(24'h0ABCDE);
        p0 = pops_seen;
        do_cycle(1, 1, 0, 1, 1, 0);
        check("coll_hdr", last_byte, 8'h00);
        check("coll_fidx", O_fast_active, 0);
        do_cycle(1, 1, 1, 1, 0, 0);
        check("coll_b1", last_byte, 8'hDE);
        do_cycle(0, 0, 0, 1, 0, 0);
        check("coll_pops", pops_seen - p0, 1);

        // 5 strobes, restart, 4 strobes with two words available.
        fifo_q.push_back(24'h112233);
        fifo_q.push_back(24'h445566);
        p0 = pops_seen;
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 1, 1, 0);
        do_cycle(0, 0, 0, 1, 0, 1);
        check("restart_idle", O_fast_active, 0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 0, 1, 1, 0);
            got[i] = last_byte;
        end
        check("restart_hdr", got[0], 8'hC0);
        check("restart_pops", pops_seen - p0, 2);
        do_cycle(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a fast frame, then a fresh register frame.
        fifo_q.push_back(24'h777777);
        do_cycle(0, 0, 0, 1, 1, 0);
        do_cycle(0, 0, 0, 1, 1, 0);
        do_reset();
        fifo_q.delete();
        fifo_q.push_back(24'h9A8B7C);
        p0 = pops_seen;
        for (int b = 0; b < 4; b++) do_cycle(1, 1, b, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);
        check("post_rst_pops", pops_seen - p0, 1);

        // Random traffic.
        rand_empty_status = 1'b1;
        begin
            bit fen = 0;
            for (int i = 0; i < 800; i++) begin
                if (($urandom % 4 == 0) && fifo_q.size() < 8) fifo_q.push_back(24'($urandom));
                if ($urandom % 16 == 0) fen = ~fen;
                do_cycle(($urandom % 3) != 0, ($urandom % 3) == 0, $urandom % 8,
                         fen, $urandom % 2, ($urandom % 20) == 0, ($urandom % 50) == 0);
            end
        end
        do_cycle(0, 0, 0, 0, 0, 0);

        // Empty-frame counter saturation and clear precedence.
        fifo_q.delete();
        do_cycle(0, 0, 0, 0, 0, 0, 1);
`ifdef FIFO_RD_STATS_EN
        for (int i = 0; i < 65537; i++) do_cycle(0, 0, 0, 1, 1, 1);
        check("empty_sat", O_empty_count, 16'hFFFF);
`else
        for (int i = 0; i < 8; i++) do_cycle(0, 0, 0, 1, 1, 1);
`endif
        fifo_q.push_back(24'h010203);
        do_cycle(0, 0, 0, 1, 1, 1, 1);
        check("clr_word", O_word_count, 0);
        check("clr_empty", O_empty_count, 0);
        do_cycle(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
